// File: rtl/tx_delay_pulser.sv
// Per-channel TX beamformer: on start, waits the beam's LUT delay, then drives a
// bipolar burst of num_cycles periods, each half-phase lasting half_period clocks.
module tx_delay_pulser #(
  parameter int unsigned ADDR_WD  = 7,
  parameter int unsigned DELAY_WD = 12,
  parameter int unsigned HP_WD    = 8,
  parameter int unsigned CYC_WD   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [ADDR_WD-1:0]  beam_idx,
  input  logic [ADDR_WD-1:0]  lut_addr,
  input  logic [DELAY_WD-1:0] lut_din,
  input  logic                lut_we,
  input  logic [HP_WD-1:0]    half_period,
  input  logic [CYC_WD-1:0]   num_cycles,
  input  logic                apo_en,
  output logic                pulse_p,
  output logic                pulse_n,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int unsigned DEPTH = 1 << ADDR_WD;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDelay,
    StPulseP,
    StPulseN,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_WD-1:0]  beam_q, beam_d;
  logic [HP_WD-1:0]    hp_q, hp_d;
  logic [CYC_WD-1:0]   cyc_q, cyc_d;
  logic                apo_q, apo_d;
  logic [DELAY_WD-1:0] dly_q, dly_d;
  logic [HP_WD-1:0]    hp_cnt_q, hp_cnt_d;
  logic                pulse_p_q, pulse_n_q;

  logic [DELAY_WD-1:0] mem [DEPTH];
  logic [DELAY_WD-1:0] rd_q;

  // Read-first: the LOAD-cycle read and a same-edge write both use NBAs, so the read sees old data.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      mem[lut_addr] <= lut_din;
    end
    if (state_q == StLoad) begin
      rd_q <= mem[beam_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    beam_d   = beam_q;
    hp_d     = hp_q;
    cyc_d    = cyc_q;
    apo_d    = apo_q;
    dly_d    = dly_q;
    hp_cnt_d = hp_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start && tx_en) begin
          state_d = StLoad;
          beam_d  = beam_idx;
          hp_d    = (half_period == '0) ? HP_WD'(1) : half_period;
          cyc_d   = num_cycles;
          apo_d   = apo_en;
        end
      end
      StLoad: begin
        state_d = StDelay;
        dly_d   = '0;
      end
      // Elapsed-count against the held LUT value: DELAY lasts D+1 cycles.
      StDelay: begin
        if (dly_q == rd_q) begin
          if (cyc_q != '0) begin
            state_d  = StPulseP;
            hp_cnt_d = hp_q - HP_WD'(1);
          end else begin
            state_d = StDone;
          end
        end else begin
          dly_d = dly_q + DELAY_WD'(1);
        end
      end
      StPulseP: begin
        if (hp_cnt_q == '0) begin
          state_d  = StPulseN;
          hp_cnt_d = hp_q - HP_WD'(1);
        end else begin
          hp_cnt_d = hp_cnt_q - HP_WD'(1);
        end
      end
      StPulseN: begin
        if (hp_cnt_q == '0) begin
          cyc_d = cyc_q - CYC_WD'(1);
          if (cyc_q == CYC_WD'(1)) begin
            state_d = StDone;
          end else begin
            state_d  = StPulseP;
            hp_cnt_d = hp_q - HP_WD'(1);
          end
        end else begin
          hp_cnt_d = hp_cnt_q - HP_WD'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StIdle && !tx_en) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      beam_q    <= '0;
      hp_q      <= '0;
      cyc_q     <= '0;
      apo_q     <= 1'b0;
      dly_q     <= '0;
      hp_cnt_q  <= '0;
      pulse_p_q <= 1'b0;
      pulse_n_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beam_q    <= beam_d;
      hp_q      <= hp_d;
      cyc_q     <= cyc_d;
      apo_q     <= apo_d;
      dly_q     <= dly_d;
      hp_cnt_q  <= hp_cnt_d;
      // Drives follow the next state, so they change on the same edge as the state and never overlap.
      pulse_p_q <= (state_d == StPulseP) && apo_d;
      pulse_n_q <= (state_d == StPulseN) && apo_d;
    end
  end

  assign pulse_p = pulse_p_q;
  assign pulse_n = pulse_n_q;
  assign tx_busy = (state_q != StIdle);
  assign tx_done = (state_q == StDone);

endmodule

// File: tb/tb_tx_delay_pulser.sv
// Self-checking bench for tx_delay_pulser: directed test-plan scenarios plus random
// bursts, compared cycle by cycle against a waveform model derived from the timing rules.
module tb_tx_delay_pulser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  beam_idx = '0;
  logic [6:0]  lut_addr = '0;
  logic [11:0] lut_din = '0;
  logic        lut_we = 1'b0;
  logic [7:0]  half_period = '0;
  logic [3:0]  num_cycles = '0;
  logic        apo_en = 1'b0;
  logic        pulse_p, pulse_n, tx_busy, tx_done;
  logic [3:0]  obs;

  int checks = 0;
  int failures = 0;
  int lut_m [128];

  always #5 clk = ~clk;

  tx_delay_pulser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .start       (start),
    .beam_idx    (beam_idx),
    .lut_addr    (lut_addr),
    .lut_din     (lut_din),
    .lut_we      (lut_we),
    .half_period (half_period),
    .num_cycles  (num_cycles),
    .apo_en      (apo_en),
    .pulse_p     (pulse_p),
    .pulse_n     (pulse_n),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  assign obs = {pulse_p, pulse_n, tx_busy, tx_done};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp, input int t);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed{p,n,busy,done}=%b expected=%b", tag, t, got, exp);
    end
  endtask

  // Expected {pulse_p, pulse_n, tx_busy, tx_done} in cycle t after start was sampled at edge 0.
  function automatic logic [3:0] model(input int t, input int d, input int h, input int n,
                                       input bit apo, input int abort_at);
    int heff, ps, last, ph;
    logic [3:0] r;
    heff = (h == 0) ? 1 : h;
    ps   = 3 + d;
    last = ps + 2 * heff * n;
    r    = 4'b0000;
    if (abort_at > 0 && t > abort_at) return r;
    r[1] = (t >= 1 && t <= last);
    r[0] = (t == last);
    if (t >= ps && t < last && apo) begin
      ph = (t - ps) / heff;
      r[3] = (ph % 2 == 0);
      r[2] = (ph % 2 == 1);
    end
    return r;
  endfunction

  // Call just after a falling edge; returns just after a falling edge.
  task automatic lut_write(input int addr, input int val);
    lut_we   = 1'b1;
    lut_addr = 7'(addr);
    lut_din  = 12'(val);
    lut_m[addr] = val;
    @(posedge clk); #1;
    lut_we = 1'b0;
    @(negedge clk);
  endtask

  // Drives start in the current cycle (cycle 0) and checks every cycle through the idle cycle after done.
  task automatic run_burst(input string tag, input int beam, input int h, input int n,
                           input bit apo, input int abort_at, input int busy_start_at,
                           input bit wr_at_load, input int wr_val, input int rst_at);
    int d, heff, last;
    d    = lut_m[beam];
    heff = (h == 0) ? 1 : h;
    last = 3 + d + 2 * heff * n;
    beam_idx    = 7'(beam);
    half_period = 8'(h);
    num_cycles  = 4'(n);
    apo_en      = apo;
    start       = 1'b1;
    for (int t = 1; t <= last + 1; t++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      lut_we = 1'b0;
      if (wr_at_load && t == 1) begin
        lut_we   = 1'b1;
        lut_addr = 7'(beam);
        lut_din  = 12'(wr_val);
        lut_m[beam] = wr_val;
      end
      if (t == abort_at) tx_en = 1'b0;
      if (t == busy_start_at) begin
        start       = 1'b1;
        beam_idx    = 7'($urandom);
        half_period = 8'($urandom);
        num_cycles  = 4'($urandom);
        apo_en      = ~apo;
      end
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_async_reset"}, obs, 4'b0000, t);
        @(negedge clk);
        chk({tag, "_in_reset"}, obs, 4'b0000, t);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      chk(tag, obs, model(t, d, h, n, apo, abort_at), t);
    end
    start  = 1'b0;
    lut_we = 1'b0;
    tx_en  = 1'b1;
  endtask

  initial begin
    int beam, val, h, n, ab;
    bit apo;

    #1;
    chk("reset_state", obs, 4'b0000, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_idle", obs, 4'b0000, 0);

    // Scenario 1: LUT[5]=10, H=4, N=2
    lut_write(5, 10);
    run_burst("basic_burst", 5, 4, 2, 1'b1, 0, 0, 1'b0, 0, 0);
    // Scenario 2: zero delay, H=0 treated as 1, back-to-back with previous done
    lut_write(0, 0);
    run_burst("min_burst", 0, 0, 1, 1'b1, 0, 0, 1'b0, 0, 0);
    // Scenario 3: N=0 gives no pulses
    lut_write(2, 7);
    run_burst("zero_cycles", 2, 3, 0, 1'b1, 0, 0, 1'b0, 0, 0);
    // Scenario 4: apodised-off channel
    run_burst("apo_off", 5, 4, 2, 1'b0, 0, 0, 1'b0, 0, 0);
    // Scenario 5: abort at cycle 18 with an ignored start while busy
    run_burst("abort_busy_start", 5, 4, 2, 1'b1, 18, 8, 1'b0, 0, 0);
    run_burst("after_abort", 5, 4, 2, 1'b1, 0, 12, 1'b0, 0, 0);
    // Scenario 6: same-cycle write during LOAD returns old data, then mid-burst reset
    run_burst("read_first", 5, 4, 2, 1'b1, 0, 0, 1'b1, 3, 0);
    run_burst("reset_mid", 5, 4, 2, 1'b1, 0, 0, 1'b0, 0, 9);
    @(negedge clk);
    run_burst("after_reset", 5, 2, 3, 1'b1, 0, 0, 1'b0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      beam = $urandom_range(0, 127);
      val  = $urandom_range(0, 40);
      h    = $urandom_range(0, 6);
      n    = $urandom_range(0, 3);
      apo  = 1'($urandom_range(0, 1));
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      lut_write(beam, val);
      run_burst("random_burst", beam, h, n, apo, ab, $urandom_range(2, 10), 1'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_delay_pulser.md
Name: tx_delay_pulser

Overview:
- Per-channel transmit beamforming block for the TX path; it is the transmit-side counterpart of the per-channel receive DBF chain.
- On a fire trigger it looks up the channel's focusing delay from a writable delay LUT indexed by beam number.
- After that delay it drives a bipolar burst (pulse_p / pulse_n) to the pulser front-end.
- One instance per element channel; all channels share start so that the LUT delays set the transmit focus.

Parameters:
ADDR_WD, 7, delay LUT address width (beam index); LUT depth 2**ADDR_WD
DELAY_WD, 12, delay LUT entry width, in clk cycles
HP_WD, 8, half-period count width
CYC_WD, 4, burst cycle count width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  transmit window; low aborts any burst in progress
start  input  1  fire trigger, single-cycle pulse
beam_idx  input  ADDR_WD  LUT entry to use; sampled with start
lut_addr  input  ADDR_WD  LUT write address
lut_din  input  DELAY_WD  LUT write data
lut_we  input  1  LUT write strobe
half_period  input  HP_WD  cycles per pulse half-phase; sampled with start
num_cycles  input  CYC_WD  full bipolar cycles per burst; sampled with start
apo_en  input  1  channel enable (TX apodisation); sampled with start
pulse_p  output  1  positive drive, registered
pulse_n  output  1  negative drive, registered
tx_busy  output  1  burst sequence in progress
tx_done  output  1  one-cycle completion strobe

Behaviour:
- Reset (asynchronous, rst_n=0): pulse_p=0, pulse_n=0, tx_busy=0, tx_done=0, state=IDLE, all counters 0. LUT contents are not reset.
- LUT:
  - 2**ADDR_WD x DELAY_WD, synchronous write on lut_we.
  - Synchronous read, read-first: a write to the entry being read in the same cycle returns the old data.
- States: IDLE, LOAD, DELAY, PULSE_P, PULSE_N, DONE.
- IDLE:
  - start=1 and tx_en=1 -> LOAD.
  - On this transition, latch beam_idx, half_period, num_cycles and apo_en.
  - half_period=0 is latched as 1.
  - start with tx_en=0 is ignored.
- LOAD: one cycle for the LUT read. Then load the delay counter with D = LUT[beam_idx] and go to DELAY.
- DELAY:
  - Count down D cycles.
  - D=0 leaves DELAY after one cycle.
  - Exit target: PULSE_P if num_cycles!=0, otherwise DONE.
- Timing: with start sampled at edge 0, pulse_p is first observed high in cycle 3+D.
- PULSE_P:
  - pulse_p = apo_en for H = half_period cycles, then PULSE_N.
  - pulse_n = apo_en for H cycles.
  - After the last PULSE_N, decrement the cycle counter. If nonzero, go to PULSE_P; else go to DONE.
  - The burst is contiguous: no gap between phases or between cycles.
- Waveform: total burst length is 2*H*num_cycles cycles. pulse_p and pulse_n are never high together, including at all transitions.
- apo_en=0: timing is identical, pulse outputs stay 0, and tx_done still fires.
- DONE: tx_done=1 for exactly one cycle, outputs 0, then IDLE. A new start is accepted in the cycle after DONE.
- tx_busy: 1 in every state except IDLE, i.e. from the cycle after start through the DONE cycle inclusive.
- start while tx_busy=1: ignored; latched config is unchanged.
- tx_en falling in any non-IDLE state (abort):
  - Next edge: state=IDLE, pulse_p=pulse_n=0, tx_busy=0.
  - No tx_done.
- LUT writes are allowed at any time; they affect a burst only if written before the LOAD-cycle read.
- Widths: counters are sized DELAY_WD, HP_WD and CYC_WD with no overflow. Maximum burst = 2*(2**HP_WD-1)*(2**CYC_WD-1) cycles.

Test Plan:
- Write LUT[5]=10; fire with beam_idx=5, H=4, N=2, apo_en=1 -> pulse_p high cycles 13-16 and 21-24, pulse_n high cycles 17-20 and 25-28, tx_done at cycle 29, tx_busy high cycles 1-29.
- LUT[0]=0, H=0, N=1 -> pulse_p high cycle 3 only, pulse_n cycle 4, tx_done cycle 5.
- N=0, LUT[2]=7 -> no pulses; tx_done at cycle 10.
- apo_en=0 with the config of the first scenario -> pulse outputs stay 0, tx_done still at cycle 29.
- Deassert tx_en at cycle 18 of the first scenario -> outputs 0 and tx_busy=0 from cycle 19, no tx_done; a second start during busy is ignored.
- Write LUT[5]=3 in the same cycle as LOAD (old value 10) -> burst uses 10. Assert rst_n=0 mid-burst -> all outputs 0 immediately, and the next fire works normally.
